frame_transmitter: RTL

- GMII-side frame transmitter. Reads one stored packet (DA..payload, no preamble, no FCS) from the packet memory through a synchronous read port.
- Emits it byte-per-clock as preamble, SFD, data, optional pad, CRC-32 FCS, then enforces the inter-frame gap.
- Loopback partner of frame_receiver: its o_tx_en/o_tx_d connect directly to the receiver's irx_dv/irx_data in benches.

---
 rtl/eth_pkg.sv | 55 +++++
 rtl/crc32_byte.sv | 27 ++
 rtl/frame_transmitter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the GMII frame transmitter and receiver.
// Contents: FSM state encoding (also reported on o_state), framing bytes,
// CRC-32 constants, default length limits, TX data-source select and the
// GMII TX bus bundle.
package eth_pkg;

  // FSM state encoding, shared by frame_transmitter and frame_receiver
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } eth_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned PREAMBLE_LEN = 7;
  localparam int unsigned FCS_LEN      = 4;

  // IEEE 802.3 CRC-32 (processed reflected, LSB first)
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam int unsigned ETH_MIN_LEN = 60;
  localparam int unsigned ETH_MAX_LEN = 1514;

  // Source of the byte currently on TXD
  typedef enum logic [1:0] {
    TXD_REG = 2'd0,
    TXD_MEM = 2'd1,
    TXD_FCS = 2'd2
  } txd_sel_e;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
  } gmii_tx_t;

  // Bit-reverse a 32-bit word (normal-form polynomial to reflected form)
  function automatic logic [31:0] reflect32(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 update by one byte (reflected, LSB first).
// Ports:
//   i_crc   : current CRC register
//   i_data  : next data byte
//   o_crc_c : CRC register after absorbing i_data (combinational)
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc_c
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] crc_w;

  // Eight serial shift steps unrolled
  always_comb begin
    crc_w = i_crc ^ {24'h000000, i_data};
    for (int i = 0; i < 8; i++) begin
      crc_w = crc_w[0] ? ((crc_w >> 1) ^ POLY_R) : (crc_w >> 1);
    end
    o_crc_c = crc_w;
  end

endmodule

// File: rtl/frame_transmitter.sv
// GMII frame transmitter: reads one stored packet from packet memory and
// sends preamble, SFD, data, optional zero pad, CRC-32 FCS, then holds the
// inter-frame gap.
// Build option: FRAME_TX_PAD_EN enables padding of short frames to pMIN_LEN.
// Ports:
//   iclk, i_rst          : clock, synchronous active-high reset
//   i_pkt_rdy, i_pkt_len : packet available and its byte length
//   i_abort              : abort the frame in progress
//   o_rd_en, o_rd_addr   : packet memory read port (data returns next cycle
//                          on i_rd_data)
//   o_pkt_done, o_len_err: packet consumed pulse, length-error qualifier
//   o_tx_en/o_tx_er/o_tx_d : GMII transmit interface
//   o_state              : current FSM state
// Output stage: every output is a flop driven from the state one cycle
// earlier, except o_tx_d, which muxes the registered byte with i_rd_data
// (memory bytes) or the running CRC (FCS bytes).
module frame_transmitter
  import eth_pkg::*;
#(
  parameter int unsigned pADDR_W  = 11,
  parameter int unsigned pMIN_LEN = ETH_MIN_LEN,
  parameter int unsigned pMAX_LEN = ETH_MAX_LEN,
  parameter int unsigned pIFG     = 12
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               i_pkt_rdy,
  input  logic [pADDR_W-1:0] i_pkt_len,
  input  logic               i_abort,
  output logic               o_rd_en,
  output logic [pADDR_W-1:0] o_rd_addr,
  input  logic [7:0]         i_rd_data,
  output logic               o_pkt_done,
  output logic               o_len_err,
  output logic               o_tx_en,
  output logic               o_tx_er,
  output logic [7:0]         o_tx_d,
  output logic [2:0]         o_state
);

`ifdef FRAME_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [pADDR_W-1:0] MAX_LEN_W = pADDR_W'(pMAX_LEN);
  localparam logic [pADDR_W-1:0] MIN_LEN_W = pADDR_W'(pMIN_LEN);
  localparam logic [pADDR_W-1:0] MIN_LAST  = pADDR_W'(pMIN_LEN - 1);
  localparam logic [pADDR_W-1:0] PRE_LAST  = pADDR_W'(PREAMBLE_LEN - 1);
  localparam logic [pADDR_W-1:0] FCS_LAST  = pADDR_W'(FCS_LEN - 1);
  // IFG state covers pIFG-1 cycles; the IDLE cycle that follows is the last gap cycle
  localparam logic [pADDR_W-1:0] IFG_LAST  = pADDR_W'(pIFG - 2);
  localparam logic [pADDR_W-1:0] ONE_W     = pADDR_W'(1);

  eth_state_e         state_q, state_d;
  logic [pADDR_W-1:0] cnt_q, cnt_d;
  logic [pADDR_W-1:0] len_q, len_d;

  gmii_tx_t           tx_q, tx_d;
  txd_sel_e           sel_q, sel_d;
  logic               crc_en_q, crc_en_d;
  logic               rd_en_q, rd_en_d;
  logic [pADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic               done_q, done_d;
  logic               len_err_q, len_err_d;
  logic [31:0]        crc_q, crc_d;

  logic        accept;
  logic        len_bad;
  logic        abortable;
  logic        abort_now;
  logic        last_byte;
  logic        pad_applies;
  logic [7:0]  tx_d_c;
  logic [31:0] crc_nxt_c;

  // One cycle after a done pulse i_pkt_rdy may still describe the old packet
  assign accept      = i_pkt_rdy && !done_q;
  assign len_bad     = (i_pkt_len == '0) || (i_pkt_len > MAX_LEN_W);
  assign abortable   = state_q inside {ST_PRE, ST_SFD, ST_DATA, ST_PAD};
  assign abort_now   = i_abort && abortable;
  assign last_byte   = (cnt_q == (len_q - ONE_W));
  assign pad_applies = PAD_EN && (len_q < MIN_LEN_W);

  // State register
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !len_bad) begin
          state_d = ST_PRE;
          cnt_d   = '0;
          len_d   = i_pkt_len;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      ST_SFD: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (last_byte) begin
          if (pad_applies) begin
            // pad counter continues the total byte count
            state_d = ST_PAD;
            cnt_d   = len_q;
          end else begin
            state_d = ST_FCS;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      ST_PAD: begin
        if (cnt_q == MIN_LAST) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      ST_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort overrides the normal transition; the error byte goes out as IFG starts
    if (abort_now) begin
      state_d = ST_IFG;
      cnt_d   = '0;
    end
  end

  // Output logic (registered next cycle)
  always_comb begin
    tx_d      = '0;
    sel_d     = TXD_REG;
    crc_en_d  = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && len_bad) begin
          done_d    = 1'b1;
          len_err_d = 1'b1;
        end
      end
      ST_PRE: begin
        tx_d.en = 1'b1;
        tx_d.d  = PREAMBLE_BYTE;
      end
      ST_SFD: begin
        tx_d.en = 1'b1;
        tx_d.d  = SFD_BYTE;
        rd_en_d = 1'b1;
      end
      ST_DATA: begin
        // byte cnt_q arrives from memory while address cnt_q+1 is requested
        tx_d.en  = 1'b1;
        sel_d    = TXD_MEM;
        crc_en_d = 1'b1;
        if (!last_byte) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q + ONE_W;
        end
      end
      ST_PAD: begin
        tx_d.en  = 1'b1;
        crc_en_d = 1'b1;
      end
      ST_FCS: begin
        tx_d.en = 1'b1;
        sel_d   = TXD_FCS;
      end
      ST_IFG: begin
        done_d = (cnt_q == '0);
      end
      default: begin
        tx_d = '0;
      end
    endcase
    if (abort_now) begin
      tx_d      = '{en: 1'b1, er: 1'b1, d: 8'h00};
      sel_d     = TXD_REG;
      crc_en_d  = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
    end
  end

  // Byte on TXD: registered constant, memory read data, or next FCS byte
  always_comb begin
    unique case (sel_q)
      TXD_MEM: tx_d_c = i_rd_data;
      TXD_FCS: tx_d_c = ~crc_q[7:0];
      default: tx_d_c = tx_q.d;
    endcase
  end

  crc32_byte u_crc (
    .i_crc   (crc_q),
    .i_data  (tx_d_c),
    .o_crc_c (crc_nxt_c)
  );

  // CRC accumulates data/pad bytes as sent, then shifts out during FCS
  always_comb begin
    crc_d = crc_q;
    if (crc_en_q) begin
      crc_d = crc_nxt_c;
    end else if (sel_q == TXD_FCS) begin
      crc_d = {8'h00, crc_q[31:8]};
    end else if (state_q == ST_IDLE) begin
      crc_d = CRC_INIT;
    end
  end

  // Output and CRC registers
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      tx_q      <= '0;
      sel_q     <= TXD_REG;
      crc_en_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      crc_q     <= CRC_INIT;
    end else begin
      tx_q      <= tx_d;
      sel_q     <= sel_d;
      crc_en_q  <= crc_en_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
      crc_q     <= crc_d;
    end
  end

  assign o_rd_en    = rd_en_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_pkt_done = done_q;
  assign o_len_err  = len_err_q;
  assign o_tx_en    = tx_q.en;
  assign o_tx_er    = tx_q.er;
  assign o_tx_d     = tx_d_c;
  assign o_state    = state_q;

endmodule
